// File: rtl/arith_seq_pkg.sv
// Shared types for the bit-serial arithmetic sequencer: opcode and FSM state
// encodings, the B-operand selection modes and the per-opcode decode function.
package arith_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD    = 3'd0,
      OP_SUBWB  = 3'd1,
      OP_MOV    = 3'd2,
      OP_SUB    = 3'd3,
      OP_INC    = 3'd4,
      OP_DEC    = 3'd5,
      OP_ADDINC = 3'd6,
      OP_RSVD   = 3'd7
   } optype_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // What the slice sees on its B input for the whole operation
   typedef enum logic [1:0] {
      BM_B    = 2'd0,
      BM_NB   = 2'd1,
      BM_ZERO = 2'd2,
      BM_ONES = 2'd3
   } bmode_t;

   // Returns {bsel-mode, initial carry} for an opcode; the reserved opcode
   // decodes to a harmless zero operand and is flagged separately.
   function automatic logic [2:0] op_decode(input optype_t op, input logic cin);
      logic [2:0] cfg;
      case (op)
         OP_ADD:    cfg = {BM_B,    cin};
         OP_SUBWB:  cfg = {BM_NB,   ~cin};
         OP_MOV:    cfg = {BM_ZERO, 1'b0};
         OP_SUB:    cfg = {BM_NB,   1'b1};
         OP_INC:    cfg = {BM_ZERO, 1'b1};
         OP_DEC:    cfg = {BM_ONES, 1'b0};
         OP_ADDINC: cfg = {BM_B,    1'b1};
         default:   cfg = {BM_ZERO, 1'b0};
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/arith_bit_slice.sv
// One-bit full adder used as the single arithmetic slice of the serial engine.
module arith_bit_slice (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/arith_serial_sequencer.sv
// Bit-serial add/sub engine: runs one full-adder slice over WIDTH cycles, LSB
// first, with valid/ready request and response handshakes, one op in flight.
// Optional feature: define ALU_FLAGS_EN to add the rsp_zero / rsp_ovf flags.
module arith_serial_sequencer
   import arith_seq_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int OPSEL_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   input  logic               req_cin,
   input  logic [OPSEL_W-1:0] req_op,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic               rsp_cout,
`ifdef ALU_FLAGS_EN
   output logic               rsp_zero,
   output logic               rsp_ovf,
`endif
   output logic               rsp_err
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   a_sh, b_sh, res_q;
   logic               carry_q, err_q;
   logic               accept, is_last, is_rsvd;
   logic               sum_bit, cout_bit;
   logic [2:0]         cfg;
   bmode_t             bmode;
   logic               c0;
   optype_t            op_in;
   logic [WIDTH-1:0]   b_init;
   logic [WIDTH-1:0]   res_next;
`ifdef ALU_FLAGS_EN
   logic               zero_q, ovf_q;
`endif

   assign op_in    = optype_t'(req_op);
   assign cfg      = op_decode(op_in, req_cin);
   assign bmode    = bmode_t'(cfg[2:1]);
   assign c0       = cfg[0];
   assign is_rsvd  = (op_in == OP_RSVD);
   assign accept   = req_valid & req_ready;
   assign is_last  = (cnt_q == CNT_W'(WIDTH - 1));
   assign res_next = {sum_bit, res_q[WIDTH-1:1]};

   // Pre-transform B once at accept so the slice only ever sees b_sh[0]
   always_comb begin
      b_init = req_b;
      case (bmode)
         BM_B:    b_init = req_b;
         BM_NB:   b_init = ~req_b;
         BM_ZERO: b_init = '0;
         BM_ONES: b_init = '1;
         default: b_init = req_b;
      endcase
   end

   arith_bit_slice u_slice (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry_q),
      .sum  (sum_bit),
      .cout (cout_bit)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake outputs; no accept while DONE, even on rsp_ready
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = is_rsvd ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (is_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand shift registers: loaded at accept, shifted right each RUN cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh <= req_a;
         b_sh <= b_init;
      end else if (state_q == ST_RUN) begin
         a_sh <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      end
   end

   // Bit counter, carry chain, result shift register and response flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         err_q   <= 1'b0;
`ifdef ALU_FLAGS_EN
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else if (accept) begin
         cnt_q   <= '0;
`ifdef ALU_FLAGS_EN
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
`endif
         if (is_rsvd) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b1;
         end else begin
            carry_q <= c0;
            err_q   <= 1'b0;
         end
      end else if (state_q == ST_RUN) begin
         cnt_q   <= cnt_q + 1'b1;
         carry_q <= cout_bit;
         res_q   <= res_next;
`ifdef ALU_FLAGS_EN
         if (is_last) begin
            zero_q <= (res_next == '0);
            ovf_q  <= carry_q ^ cout_bit;
         end
`endif
      end
   end

   assign rsp_result = res_q;
   assign rsp_cout   = carry_q;
   assign rsp_err    = err_q;
`ifdef ALU_FLAGS_EN
   assign rsp_zero   = zero_q;
   assign rsp_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_arith_serial_sequencer.sv
// Randomised and directed bench for arith_serial_sequencer against a plain
// arithmetic reference model (WIDTH=32).
module tb_arith_serial_sequencer;

   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_cin;
   logic [WIDTH-1:0]  req_a, req_b;
   logic [2:0]        req_op;
   logic              rsp_valid, rsp_ready, rsp_cout, rsp_err;
   logic [WIDTH-1:0]  rsp_result;
`ifdef ALU_FLAGS_EN
   logic              rsp_zero, rsp_ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   arith_serial_sequencer #(.WIDTH(WIDTH), .OPSEL_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_cin    (req_cin),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_cout   (rsp_cout),
`ifdef ALU_FLAGS_EN
      .rsp_zero   (rsp_zero),
      .rsp_ovf    (rsp_ovf),
`endif
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: result = A + Bsel + c0 computed on 33 bits
   task automatic model(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, output logic [WIDTH-1:0] r, output logic co,
                        output logic err, output logic zero, output logic ovf);
      logic [WIDTH-1:0] bs;
      logic             c;
      logic [WIDTH:0]   s;
      err = 1'b0;
      case (op)
         3'd0: begin bs = b;   c = cin;  end
         3'd1: begin bs = ~b;  c = ~cin; end
         3'd2: begin bs = '0;  c = 1'b0; end
         3'd3: begin bs = ~b;  c = 1'b1; end
         3'd4: begin bs = '0;  c = 1'b1; end
         3'd5: begin bs = '1;  c = 1'b0; end
         3'd6: begin bs = b;   c = 1'b1; end
         default: begin bs = '0; c = 1'b0; err = 1'b1; end
      endcase
      s = {1'b0, a} + {1'b0, bs} + {{WIDTH{1'b0}}, c};
      if (err) begin
         r = '0; co = 1'b0; zero = 1'b0; ovf = 1'b0;
      end else begin
         r    = s[WIDTH-1:0];
         co   = s[WIDTH];
         zero = (r == '0);
         ovf  = (a[WIDTH-1] == bs[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
   endtask

   task automatic check_rsp(input string tag, input logic [WIDTH-1:0] er, input logic ec,
                            input logic ee, input logic ez, input logic eo);
      check_eq({tag, ".result"}, 64'(rsp_result), 64'(er));
      check_eq({tag, ".cout"},   64'(rsp_cout),   64'(ec));
      check_eq({tag, ".err"},    64'(rsp_err),    64'(ee));
`ifdef ALU_FLAGS_EN
      check_eq({tag, ".zero"},   64'(rsp_zero),   64'(ez));
      check_eq({tag, ".ovf"},    64'(rsp_ovf),    64'(eo));
`else
      if (ez === 1'bx || eo === 1'bx) $display("note: unknown flag model value");
`endif
   endtask

   // Issue one op (called at a negedge), check latency, response, DONE hold behaviour
   task automatic run_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin, input int hold);
      logic [WIDTH-1:0] er;
      logic ec, ee, ez, eo;
      int t;
      int lat;
      model(op, a, b, cin, er, ec, ee, ez, eo);
      req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
      t = 0;
      while (!req_ready && t < 100) begin @(negedge clk); t++; end
      check_eq({tag, ".accept_wait"}, 64'(t < 100), 64'd1);
      @(posedge clk);
      @(negedge clk);
      // Inputs change after accept and must be ignored
      req_valid = 1'b0;
      req_a = $urandom; req_b = $urandom; req_op = 3'($urandom); req_cin = 1'($urandom);
      lat = 0;
      while (!rsp_valid && lat < WIDTH + 5) begin @(negedge clk); lat++; end
      check_eq({tag, ".latency"}, 64'(lat), (op == 3'd7) ? 64'd0 : 64'(WIDTH));
      check_rsp(tag, er, ec, ee, ez, eo);
      check_eq({tag, ".req_ready_done"}, 64'(req_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         @(negedge clk);
         check_eq({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
         check_eq({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
         check_eq({tag, ".hold_result"}, 64'(rsp_result), 64'(er));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      check_eq({tag, ".hs_ready"}, 64'(req_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq({tag, ".after_hs_valid"}, 64'(rsp_valid), 64'd0);
      check_eq({tag, ".after_hs_ready"}, 64'(req_ready), 64'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, ".req_ready"}, 64'(req_ready), 64'd1);
      check_eq({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
      check_rsp(tag, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic [2:0] rop;
      req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0; req_op = '0;
      rsp_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_state("post_reset");

      run_op("add_wrap",  3'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run_op("sub",       3'd3, 32'd5, 32'd7, 1'b0, 0);
      run_op("subwb",     3'd1, 32'd10, 32'd3, 1'b1, 0);
      run_op("mov",       3'd2, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 0);
      run_op("inc",       3'd4, 32'h7FFF_FFFF, 32'd0, 1'b0, 0);
      run_op("inc_wrap",  3'd4, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
      run_op("dec",       3'd5, 32'd0, 32'd0, 1'b0, 0);
      run_op("addinc",    3'd6, 32'd2, 32'd3, 1'b0, 0);
      run_op("rsvd",      3'd7, 32'h1111_1111, 32'h2222_2222, 1'b1, 0);
      run_op("clear_err", 3'd0, 32'd4, 32'd5, 1'b1, 0);
      run_op("stall",     3'd3, 32'h8000_0000, 32'd1, 1'b0, 10);

      // Reset asserted while bit 12 is being processed
      req_op = 3'd0; req_a = 32'hAAAA_5555; req_b = 32'h1357_9BDF; req_cin = 1'b1;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (12) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_state("mid_run_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("after_reset", 3'd0, 32'hAAAA_5555, 32'h1357_9BDF, 1'b1, 0);

      for (int k = 0; k < 30; k++) begin
         ra  = (k % 5 == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         rb  = (k % 7 == 0) ? 32'h8000_0000 : 32'($urandom);
         rop = 3'($urandom_range(0, 7));
         run_op($sformatf("rand%0d", k), rop, ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
